// File: rtl/slot_allocator_pkg.sv
// Shared pool configuration: default depth and slot index type.
package slot_allocator_pkg;
  localparam int SLOT_DEPTH = 16;
  localparam int SLOT_ID_W  = $clog2(SLOT_DEPTH);
  typedef logic [SLOT_ID_W-1:0] slot_id_t;
endpackage

// File: rtl/slot_allocator_if.sv
// Alloc/release handshake and bookkeeping bus between a consumer and the allocator.
interface slot_allocator_if
  import slot_allocator_pkg::*;
#(
  parameter int DEPTH = SLOT_DEPTH,
  parameter int ID_W  = $clog2(DEPTH)
);
  logic            flush;
  logic            alloc_req;
  logic            alloc_ready;
  logic [ID_W-1:0] alloc_id;
  logic            release0_valid;
  logic [ID_W-1:0] release0_id;
  logic            release1_valid;
  logic [ID_W-1:0] release1_id;
  logic [DEPTH-1:0] busy_map;
  logic [ID_W:0]   free_count;
  logic            err_bad_release;

  modport master (
    output flush, alloc_req, release0_valid, release0_id, release1_valid, release1_id,
    input  alloc_ready, alloc_id, busy_map, free_count, err_bad_release
  );
  modport slave (
    input  flush, alloc_req, release0_valid, release0_id, release1_valid, release1_id,
    output alloc_ready, alloc_id, busy_map, free_count, err_bad_release
  );
endinterface

// File: rtl/slot_allocator_priority_finder.sv
// Priority search: index of the lowest (FIRST_PRIORITY=1) or highest set request bit.
module priority_finder #(
  parameter int WIDTH          = 16,
  parameter int FIRST_PRIORITY = 1,
  parameter int IW             = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IW-1:0]    index_o,
  output logic             index_valid_o
);
  // Scan so the last hit written is the winning one; index defaults to 0 when nothing is set.
  always_comb begin
    index_o       = '0;
    index_valid_o = |req_i;
    if (FIRST_PRIORITY != 0) begin
      for (int i = WIDTH-1; i >= 0; i--)
        if (req_i[i]) index_o = IW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (req_i[i]) index_o = IW'(i);
    end
  end
endmodule

// File: rtl/slot_allocator.sv
// Busy-bitmap slot allocator: lowest-free grant, two release ports, flush, sticky bad-release flag.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int DEPTH = SLOT_DEPTH,
  localparam int ID_W = $clog2(DEPTH),
  localparam int CW   = ID_W + 1
) (
  input  logic clk,
  input  logic rst,
  slot_allocator_if.slave bus
);
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  free_idx;
  logic             free_vld;
  logic             fire, eff0, eff1, bad0, bad1;

  priority_finder #(.WIDTH(DEPTH), .FIRST_PRIORITY(1)) u_pf (
    .req_i         (~busy_q),
    .index_o       (free_idx),
    .index_valid_o (free_vld)
  );

  assign bus.alloc_ready     = free_vld && !bus.flush;
  assign bus.alloc_id        = free_idx;
  assign bus.busy_map        = busy_q;
  assign bus.free_count      = cnt_q;
  assign bus.err_bad_release = err_q;

  // Release decode against the registered map; a duplicate id on port 1 is folded into port 0.
  always_comb begin
    fire = bus.alloc_req && bus.alloc_ready;
    eff0 = bus.release0_valid && busy_q[bus.release0_id];
    eff1 = bus.release1_valid && busy_q[bus.release1_id]
           && !(bus.release0_valid && (bus.release0_id == bus.release1_id));
    bad0 = bus.release0_valid && !busy_q[bus.release0_id];
    bad1 = bus.release1_valid && !busy_q[bus.release1_id];
  end

  // Next state: grant and releases hit disjoint slots, so no ordering between them matters.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (bus.flush) begin
      busy_d = '0;
      cnt_d  = CW'(DEPTH);
    end else begin
      if (fire) busy_d[free_idx]        = 1'b1;
      if (eff0) busy_d[bus.release0_id] = 1'b0;
      if (eff1) busy_d[bus.release1_id] = 1'b0;
      cnt_d = cnt_q - CW'(fire) + CW'(eff0) + CW'(eff1);
      err_d = err_q | bad0 | bad1;
    end
  end

  // State registers; rst beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= CW'(DEPTH);
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_slot_allocator.sv
// Directed bench for slot_allocator (DEPTH=16).
module tb_slot_allocator;
  localparam int DEPTH = 16;
  localparam int ID_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  slot_allocator_if #(.DEPTH(DEPTH)) bus ();

  slot_allocator #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush          = 1'b0;
    bus.alloc_req      = 1'b0;
    bus.release0_valid = 1'b0;
    bus.release0_id    = '0;
    bus.release1_valid = 1'b0;
    bus.release1_id    = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy_map !== 16'h0000) begin n_bad++; $display("FAIL reset_busy got=%h want=0000", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd16) begin n_bad++; $display("FAIL reset_cnt got=%0d want=16", bus.free_count); end
    n_cmp++; if (bus.err_bad_release !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", bus.err_bad_release); end
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.alloc_ready); end
    n_cmp++; if (bus.alloc_id !== 4'd0) begin n_bad++; $display("FAIL reset_id got=%0d want=0", bus.alloc_id); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      n_cmp++; if (bus.alloc_ready !== 1'b1 || bus.alloc_id !== ID_W'(i)) begin
        n_bad++; $display("FAIL fill_grant i=%0d got ready=%b id=%0d want ready=1 id=%0d", i, bus.alloc_ready, bus.alloc_id, i);
      end
      tick();
      n_cmp++; if (bus.free_count !== 5'(DEPTH-1-i)) begin
        n_bad++; $display("FAIL fill_cnt i=%0d got=%0d want=%0d", i, bus.free_count, DEPTH-1-i);
      end
    end
    bus.alloc_req = 1'b0;
    #1;
    n_cmp++; if (bus.busy_map !== 16'hFFFF) begin n_bad++; $display("FAIL fill_busy got=%h want=ffff", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd0) begin n_bad++; $display("FAIL fill_cnt0 got=%0d want=0", bus.free_count); end
    n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got=%b want=0", bus.alloc_ready); end
  endtask

  task automatic test_full_release();
    bus.alloc_req      = 1'b1;   // dropped: pool full
    bus.release0_valid = 1'b1;
    bus.release0_id    = 4'd5;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got=%b want=1", bus.alloc_ready); end
    n_cmp++; if (bus.alloc_id !== 4'd5) begin n_bad++; $display("FAIL rel_id got=%0d want=5", bus.alloc_id); end
    n_cmp++; if (bus.free_count !== 5'd1) begin n_bad++; $display("FAIL rel_cnt got=%0d want=1", bus.free_count); end
    n_cmp++; if (bus.busy_map !== 16'hFFDF) begin n_bad++; $display("FAIL rel_busy got=%h want=ffdf", bus.busy_map); end
    bus.alloc_req = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'hFFFF) begin n_bad++; $display("FAIL realloc_busy got=%h want=ffff", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd0) begin n_bad++; $display("FAIL realloc_cnt got=%0d want=0", bus.free_count); end
  endtask

  task automatic test_alloc_with_release();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.alloc_req = 1'b1;
    repeat (4) tick();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h000F) begin n_bad++; $display("FAIL ar_setup got=%h want=000f", bus.busy_map); end
    bus.release0_valid = 1'b1; bus.release0_id = 4'd0;
    bus.release1_valid = 1'b1; bus.release1_id = 4'd2;
    #1;
    n_cmp++; if (bus.alloc_id !== 4'd4 || bus.alloc_ready !== 1'b1) begin
      n_bad++; $display("FAIL ar_grant got ready=%b id=%0d want ready=1 id=4", bus.alloc_ready, bus.alloc_id);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h001A) begin n_bad++; $display("FAIL ar_busy got=%h want=001a", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd13) begin n_bad++; $display("FAIL ar_cnt got=%0d want=13", bus.free_count); end
    n_cmp++; if (bus.alloc_id !== 4'd0) begin n_bad++; $display("FAIL ar_next_id got=%0d want=0", bus.alloc_id); end
  endtask

  task automatic test_dual_release();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.alloc_req = 1'b1;
    repeat (2) tick();
    idle();
    bus.release0_valid = 1'b1; bus.release0_id = 4'd1;
    bus.release1_valid = 1'b1; bus.release1_id = 4'd1;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h0001) begin n_bad++; $display("FAIL dup_busy got=%h want=0001", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd15) begin n_bad++; $display("FAIL dup_cnt got=%0d want=15", bus.free_count); end
    n_cmp++; if (bus.err_bad_release !== 1'b0) begin n_bad++; $display("FAIL dup_err got=%b want=0", bus.err_bad_release); end
    bus.release0_valid = 1'b1; bus.release0_id = 4'd7;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.err_bad_release !== 1'b1) begin n_bad++; $display("FAIL bad_err got=%b want=1", bus.err_bad_release); end
    n_cmp++; if (bus.busy_map !== 16'h0001) begin n_bad++; $display("FAIL bad_busy got=%h want=0001", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd15) begin n_bad++; $display("FAIL bad_cnt got=%0d want=15", bus.free_count); end
  endtask

  task automatic test_flush();
    // busy=0001 and err=1 carried from the previous test; fill slots 1..7
    bus.alloc_req = 1'b1;
    repeat (7) tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h00FF) begin n_bad++; $display("FAIL fl_setup got=%h want=00ff", bus.busy_map); end
    bus.flush = 1'b1;
    bus.alloc_req = 1'b1;
    bus.release0_valid = 1'b1; bus.release0_id = 4'd3;
    #1;
    n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready got=%b want=0", bus.alloc_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h0000) begin n_bad++; $display("FAIL fl_busy got=%h want=0000", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd16) begin n_bad++; $display("FAIL fl_cnt got=%0d want=16", bus.free_count); end
    n_cmp++; if (bus.err_bad_release !== 1'b1) begin n_bad++; $display("FAIL fl_err got=%b want=1", bus.err_bad_release); end
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL fl_ready_after got=%b want=1", bus.alloc_ready); end
    // releases of free slots during flush must not raise the error
    rst = 1'b1; tick(); rst = 1'b0;
    bus.flush = 1'b1;
    bus.release1_valid = 1'b1; bus.release1_id = 4'd9;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.err_bad_release !== 1'b0) begin n_bad++; $display("FAIL fl_noerr got=%b want=0", bus.err_bad_release); end
  endtask

  task automatic test_reset_mid();
    bus.alloc_req = 1'b1;
    repeat (3) tick();
    bus.release0_valid = 1'b1; bus.release0_id = 4'd12;   // free slot: would set err
    tick();
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.release1_valid = 1'b1; bus.release1_id = 4'd0;
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++; if (bus.busy_map !== 16'h0000) begin n_bad++; $display("FAIL rm_busy got=%h want=0000", bus.busy_map); end
    n_cmp++; if (bus.free_count !== 5'd16) begin n_bad++; $display("FAIL rm_cnt got=%0d want=16", bus.free_count); end
    n_cmp++; if (bus.err_bad_release !== 1'b0) begin n_bad++; $display("FAIL rm_err got=%b want=0", bus.err_bad_release); end
    n_cmp++; if (bus.alloc_id !== 4'd0) begin n_bad++; $display("FAIL rm_id got=%0d want=0", bus.alloc_id); end
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got=%b want=1", bus.alloc_ready); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full_release();
    test_alloc_with_release();
    test_dual_release();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Tracks a DEPTH-entry busy bitmap for a shared resource pool (issue-queue slots, checkpoint entries, physical-ID pool).
- Hands out the lowest-indexed free slot on request.
- Reclaims slots through two release ports per cycle.
- Sits directly upstream of the lowest-index priority search: it owns the state that the search consumes, plus the alloc/release handshake and bookkeeping.

Parameters:
- DEPTH, 16, number of slots; power of 2, minimum 2.
- ID_W, $clog2(DEPTH), slot index width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  frees all slots at the next edge.
- alloc_req  input  1  consumer requests one slot this cycle.
- alloc_ready  output  1  a free slot exists and flush is low.
- alloc_id  output  ID_W  lowest-indexed free slot; valid when alloc_ready=1.
- release0_valid  input  1  release port 0 strobe.
- release0_id  input  ID_W  slot released on port 0.
- release1_valid  input  1  release port 1 strobe.
- release1_id  input  ID_W  slot released on port 1.
- busy_map  output  DEPTH  registered busy bitmap; bit i = slot i allocated.
- free_count  output  ID_W+1  registered count of free slots, range 0..DEPTH.
- err_bad_release  output  1  sticky flag: a release targeted a non-busy slot.

Behaviour:
- Reset (rst=1 at an edge):
  - busy_map=0, free_count=DEPTH, err_bad_release=0.
  - The first cycle after reset: alloc_ready=1, alloc_id=0.
- alloc_ready and alloc_id are combinational from the registered busy_map and flush only. There is no combinational path from alloc_req or the release ports.
  - alloc_ready = (busy_map != all-ones) && !flush.
  - alloc_id = lowest i with busy_map[i]=0. When all slots are busy, alloc_id=0 and is don't-care.
- Alloc fire = alloc_req && alloc_ready.
  - On fire, alloc_id is the granted slot in that same cycle.
  - busy_map[alloc_id] is set at the next edge.
  - Exactly one grant per cycle maximum.
  - alloc_req while alloc_ready=0 is dropped; the consumer holds or retries.
- Release port k is effective when releaseK_valid=1 and busy_map[releaseK_id]=1 (registered value).
  - An effective release clears the bit at the next edge.
  - A non-effective release (slot already free) changes no state except setting err_bad_release=1 at the next edge.
- Both ports valid with the same id:
  - If the slot is busy: one effective release; free_count +1, not +2; no error.
  - If the slot is free: error set once.
- Alloc and release in the same cycle:
  - No bypass: the allocator searches the pre-release bitmap.
  - A slot released in cycle N can be granted no earlier than cycle N+1.
  - Alloc and effective releases always touch disjoint slots.
- free_count next = free_count − fire + (number of distinct effective releases). Invariant, checked at every edge: free_count == DEPTH − popcount(busy_map).
- Flush:
  - At the next edge: busy_map=0, free_count=DEPTH.
  - Flush overrides any alloc and any release in that cycle; alloc_ready=0 while flush=1, so no grant can be lost.
  - Releases during flush are ignored and do not set err_bad_release.
  - err_bad_release is preserved across flush; only rst clears it.
- Full pool: alloc_ready=0. A release at edge N makes alloc_ready=1 in cycle N+1, with alloc_id equal to the released slot if it is the lowest free one.
- Reset mid-operation: rst has priority over flush, alloc and release. State equals the reset state after the edge regardless of other inputs.
- Latency: grant visible same cycle; bookkeeping visible on the outputs one cycle later.

Decomposition:
- Shared package (riscv core config/common headers):
  - DEPTH constants per pool instance.
  - A slot_id_t typedef per pool.
- Sub-module: priority_finder with FIRST_PRIORITY=1, WIDTH=DEPTH, driven by ~busy_map. Its index feeds alloc_id; its index_valid ANDed with !flush gives alloc_ready.
- Release decode, popcount-free counter update and error logic stay in slot_allocator.

Test Plan:
- Reset then 16 back-to-back alloc_req (DEPTH=16) -> grants 0,1,…,15 in consecutive cycles; after the last edge busy_map=0xFFFF, free_count=0, alloc_ready=0.
- Full pool; release0 id=5 at cycle N -> cycle N+1: alloc_ready=1, alloc_id=5, free_count=1; alloc at N+1 -> busy_map=0xFFFF at N+2.
- busy_map=0x000F; alloc_req with release0 id=0 and release1 id=2 in the same cycle -> grant id=4; next busy_map=0x001A, free_count=13.
- busy_map=0x0003; release0 id=1 and release1 id=1 -> busy_map=0x0001, free_count=15, err=0. Then release0 id=7 -> err_bad_release=1, busy_map unchanged.
- busy_map=0x00FF; flush=1 with alloc_req=1 and release0 id=3 -> alloc_ready=0 that cycle, no grant; next busy_map=0, free_count=16; err unchanged.
- rst asserted during alloc fire with flush=1 -> next cycle busy_map=0, free_count=16, err=0, alloc_id=0, alloc_ready=1.
